// File: rtl/pll_clk_sequencer.sv
// rtl/pll_clk_sequencer.sv - PLL reset/lock sequencer with staged clock enables and system reset release
// Holds the PLL in reset, waits for a stable lock, ramps the clock enables one by one, then releases sys_rstn.
module pll_clk_sequencer #(
  parameter int NUM_CLK       = 5,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int ENCLK_GAP     = 8,
  parameter int RSTN_DELAY    = 16,
  parameter int MAX_RETRY     = 3
) (
  input  logic               i_clkin,
  input  logic               i_rst_n,
  input  logic               i_pll_lock,
  input  logic               i_restart,
  output logic               o_pll_reset,
  output logic [NUM_CLK-1:0] o_enclk,
  output logic               o_sys_rstn,
  output logic               o_ready,
  output logic               o_fail,
  output logic [3:0]         o_retry_cnt
);

  localparam int EN_CYCLES = (NUM_CLK - 1) * ENCLK_GAP + RSTN_DELAY;
  localparam int MAX_A     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B     = (STABLE_CYCLES > EN_CYCLES) ? STABLE_CYCLES : EN_CYCLES;
  localparam int CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW        = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    S_PRST  = 3'd0,
    S_WLOCK = 3'd1,
    S_STAB  = 3'd2,
    S_EN    = 3'd3,
    S_RDY   = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               r_sync1;
  logic               r_sync2;
  logic               w_lock_s;
  logic [3:0]         r_retry;
  logic [3:0]         w_retry_nxt;
  logic               w_reseq;
  logic               r_pll_reset;
  logic [NUM_CLK-1:0] r_enclk;
  logic               r_sys_rstn;
  logic               r_ready;
  logic               r_fail;
  logic               w_pll_reset_nxt;
  logic [NUM_CLK-1:0] w_enclk_nxt;
  logic               w_sys_rstn_nxt;
  logic               w_ready_nxt;
  logic               w_fail_nxt;

  assign w_lock_s = r_sync2;

  // State, counter, synchronizer and registered outputs
  always_ff @(posedge i_clkin or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_PRST;
      r_cnt       <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_retry     <= 4'd0;
      r_pll_reset <= 1'b1;
      r_enclk     <= '0;
      r_sys_rstn  <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sync1     <= i_pll_lock;
      r_sync2     <= r_sync1;
      r_retry     <= w_retry_nxt;
      r_pll_reset <= w_pll_reset_nxt;
      r_enclk     <= w_enclk_nxt;
      r_sys_rstn  <= w_sys_rstn_nxt;
      r_ready     <= w_ready_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  // Next state: restart beats lock loss, lock loss beats the lock timeout
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_reseq     = 1'b0;
    if (i_restart) begin
      w_state_nxt = S_PRST;
      w_retry_nxt = 4'd0;
      w_reseq     = 1'b1;
    end else if ((r_state == S_EN || r_state == S_RDY) && !w_lock_s) begin
      w_state_nxt = S_PRST;
      w_reseq     = 1'b1;
    end else begin
      case (r_state)
        S_PRST: begin
          if (r_cnt == CW'(RST_CYCLES - 1)) w_state_nxt = S_WLOCK;
        end
        S_WLOCK: begin
          if (w_lock_s) begin
            w_state_nxt = S_STAB;
          end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
            if (r_retry == 4'(MAX_RETRY)) begin
              w_state_nxt = S_FAIL;
            end else begin
              w_state_nxt = S_PRST;
              if (r_retry != 4'hf) w_retry_nxt = r_retry + 4'd1;
            end
          end
        end
        S_STAB: begin
          if (!w_lock_s) w_state_nxt = S_WLOCK;
          else if (r_cnt == CW'(STABLE_CYCLES - 1)) w_state_nxt = S_EN;
        end
        S_EN: begin
          if (r_cnt == CW'(EN_CYCLES - 1)) begin
            w_state_nxt = S_RDY;
            w_retry_nxt = 4'd0;
          end
        end
        default: ;
      endcase
    end

    // Every state entry (including a same-state restart) starts the counter from zero
    if (w_state_nxt != r_state || w_reseq) begin
      w_cnt_nxt = '0;
    end else if (r_state == S_PRST || r_state == S_WLOCK || r_state == S_STAB || r_state == S_EN) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Outputs follow the upcoming state so they line up with it after the edge
  always_comb begin
    w_pll_reset_nxt = (w_state_nxt == S_PRST) || (w_state_nxt == S_FAIL);
    w_fail_nxt      = (w_state_nxt == S_FAIL);
    w_sys_rstn_nxt  = (w_state_nxt == S_RDY);
    w_ready_nxt     = (w_state_nxt == S_RDY);
    w_enclk_nxt     = '0;
    for (int k = 0; k < NUM_CLK; k++) begin
      w_enclk_nxt[k] = (w_state_nxt == S_RDY) ||
                       ((w_state_nxt == S_EN) && (w_cnt_nxt >= CW'(k * ENCLK_GAP)));
    end
  end

  assign o_pll_reset = r_pll_reset;
  assign o_enclk     = r_enclk;
  assign o_sys_rstn  = r_sys_rstn;
  assign o_ready     = r_ready;
  assign o_fail      = r_fail;
  assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// tb/tb_pll_clk_sequencer.sv - scoreboard bench for pll_clk_sequencer
// Stimulus queues expected output changes with their cycle; a monitor compares every observed change.
`timescale 1ns/1ps
module tb_pll_clk_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic [4:0] enclk;
  logic       sys_rstn;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          b;
  int          q_cyc[$];
  logic [12:0] q_val[$];

  pll_clk_sequencer #(
    .NUM_CLK(5), .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
    .ENCLK_GAP(2), .RSTN_DELAY(3), .MAX_RETRY(2)
  ) dut (
    .i_clkin(clk), .i_rst_n(rst_n), .i_pll_lock(pll_lock), .i_restart(restart),
    .o_pll_reset(pll_reset), .o_enclk(enclk), .o_sys_rstn(sys_rstn),
    .o_ready(ready), .o_fail(fail), .o_retry_cnt(retry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: any change of the output vector must match the next queued expectation
  initial begin
    logic [12:0] w;
    logic [12:0] prev;
    logic [12:0] ev_val;
    int          ev_cyc;
    prev = '1;
    forever begin
      @(negedge clk);
      w = {pll_reset, enclk, sys_rstn, ready, fail, retry_cnt};
      if (w != prev) begin
        prev = w;
        n_checks = n_checks + 1;
        if (q_val.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_change cyc=%0d got=%h required=none", cyc, w);
        end else begin
          ev_cyc = q_cyc.pop_front();
          ev_val = q_val.pop_front();
          if (ev_cyc != cyc || ev_val != w) begin
            n_fail = n_fail + 1;
            $display("FAIL output_change cyc=%0d got=%h required cyc=%0d val=%h", cyc, w, ev_cyc, ev_val);
          end
        end
      end
    end
  end

  // Expected output vector {pll_reset, enclk, sys_rstn, ready, fail, retry_cnt} from cycle c onward
  task automatic ev(input int c, input logic pr, input logic [4:0] en, input logic rd,
                    input logic fl, input logic [3:0] rc);
    q_cyc.push_back(c);
    q_val.push_back({pr, en, rd, rd, fl, rc});
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int          lc;
    logic [12:0] lv;
    rst_n    = 1'b1;
    pll_lock = 1'b0;
    restart  = 1'b0;
    ev(1, 1, 5'h00, 0, 0, 4'd0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b = 2;

    // Nominal sequence, then restart coinciding with lock loss in S_RDY
    ev(b+4,  0, 5'h00, 0, 0, 4'd0);
    ev(b+16, 0, 5'h01, 0, 0, 4'd0);
    ev(b+18, 0, 5'h03, 0, 0, 4'd0);
    ev(b+20, 0, 5'h07, 0, 0, 4'd0);
    ev(b+22, 0, 5'h0f, 0, 0, 4'd0);
    ev(b+24, 0, 5'h1f, 0, 0, 4'd0);
    ev(b+27, 0, 5'h1f, 1, 0, 4'd0);
    ev(b+31, 1, 5'h00, 0, 0, 4'd0);
    at(b+5);  pll_lock = 1'b1;
    at(b+28); pll_lock = 1'b0;
    at(b+30); restart = 1'b1;
    at(b+31); restart = 1'b0;
    b = b + 31;

    // Two lock timeouts, then lock succeeds on the third attempt
    ev(b+4,  0, 5'h00, 0, 0, 4'd0);
    ev(b+24, 1, 5'h00, 0, 0, 4'd1);
    ev(b+28, 0, 5'h00, 0, 0, 4'd1);
    ev(b+48, 1, 5'h00, 0, 0, 4'd2);
    ev(b+52, 0, 5'h00, 0, 0, 4'd2);
    ev(b+64, 0, 5'h01, 0, 0, 4'd2);
    ev(b+66, 0, 5'h03, 0, 0, 4'd2);
    ev(b+68, 0, 5'h07, 0, 0, 4'd2);
    ev(b+70, 0, 5'h0f, 0, 0, 4'd2);
    ev(b+72, 0, 5'h1f, 0, 0, 4'd2);
    ev(b+75, 0, 5'h1f, 1, 0, 4'd0);
    ev(b+78, 1, 5'h00, 0, 0, 4'd0);
    at(b+53); pll_lock = 1'b1;
    at(b+77); restart = 1'b1;
    at(b+78); restart = 1'b0;
    b = b + 78;

    // One-cycle lock glitch at stable count 5, then lock loss after enclk=00111
    ev(b+4,  0, 5'h00, 0, 0, 4'd0);
    ev(b+19, 0, 5'h01, 0, 0, 4'd0);
    ev(b+21, 0, 5'h03, 0, 0, 4'd0);
    ev(b+23, 0, 5'h07, 0, 0, 4'd0);
    ev(b+25, 0, 5'h0f, 0, 0, 4'd0);
    ev(b+26, 1, 5'h00, 0, 0, 4'd0);
    at(b+7);  pll_lock = 1'b0;
    at(b+8);  pll_lock = 1'b1;
    at(b+23); pll_lock = 1'b0;
    at(b+26); pll_lock = 1'b1;
    b = b + 26;

    // Full re-sequence after lock loss, then lock loss from S_RDY
    ev(b+4,  0, 5'h00, 0, 0, 4'd0);
    ev(b+13, 0, 5'h01, 0, 0, 4'd0);
    ev(b+15, 0, 5'h03, 0, 0, 4'd0);
    ev(b+17, 0, 5'h07, 0, 0, 4'd0);
    ev(b+19, 0, 5'h0f, 0, 0, 4'd0);
    ev(b+21, 0, 5'h1f, 0, 0, 4'd0);
    ev(b+24, 0, 5'h1f, 1, 0, 4'd0);
    ev(b+28, 1, 5'h00, 0, 0, 4'd0);
    at(b+25); pll_lock = 1'b0;
    b = b + 28;

    // Lock never comes: three timeouts to S_FAIL, restart clears fail and retries
    ev(b+4,  0, 5'h00, 0, 0, 4'd0);
    ev(b+24, 1, 5'h00, 0, 0, 4'd1);
    ev(b+28, 0, 5'h00, 0, 0, 4'd1);
    ev(b+48, 1, 5'h00, 0, 0, 4'd2);
    ev(b+52, 0, 5'h00, 0, 0, 4'd2);
    ev(b+72, 1, 5'h00, 0, 1, 4'd2);
    ev(b+81, 1, 5'h00, 0, 0, 4'd0);
    at(b+80); restart = 1'b1; pll_lock = 1'b1;
    at(b+81); restart = 1'b0;
    b = b + 81;

    // rst_n asserted between edges while in S_EN
    ev(b+4,  0, 5'h00, 0, 0, 4'd0);
    ev(b+13, 0, 5'h01, 0, 0, 4'd0);
    ev(b+15, 0, 5'h03, 0, 0, 4'd0);
    ev(b+17, 0, 5'h07, 0, 0, 4'd0);
    ev(b+18, 1, 5'h00, 0, 0, 4'd0);
    at(b+17);
    @(posedge clk);
    #1 rst_n = 1'b0;
    at(b+20); rst_n = 1'b1;
    b = b + 20;
    ev(b+4,  0, 5'h00, 0, 0, 4'd0);
    at(b+8);
    @(negedge clk);

    while (q_val.size() > 0) begin
      lc = q_cyc.pop_front();
      lv = q_val.pop_front();
      n_checks = n_checks + 1;
      n_fail = n_fail + 1;
      $display("FAIL missing_change got=none required cyc=%0d val=%h", lc, lv);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_clk_sequencer.md
Name: pll_clk_sequencer

Overview:
Power-up and recovery controller for the five-output system PLL. It drives the PLL reset and consumes the PLL lock, then enables the PLL output clocks one at a time in a fixed order. After the last clock is enabled it releases the synchronous system reset. It runs on the free-running 50 MHz board clock, re-sequences on lock loss, and retries a bounded number of times when the PLL fails to lock.

Parameters:
NUM_CLK, 5, number of PLL clock enables driven (enclk bit 0 first)
RST_CYCLES, 16, clkin cycles pll_reset is held high per attempt
LOCK_TIMEOUT, 50000, clkin cycles to wait for lock per attempt (1 ms)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before enabling clocks
ENCLK_GAP, 8, clkin cycles between successive enclk bit assertions
RSTN_DELAY, 16, clkin cycles from last enclk bit to sys_rstn release
MAX_RETRY, 3, lock-timeout retries before declaring failure

Ports:
clkin  in  1  free-running reference clock; also feeds the PLL input
rst_n  in  1  asynchronous active-low reset
pll_lock  in  1  PLL lock, asynchronous to clkin
restart  in  1  synchronous pulse; forces a full re-sequence
pll_reset  out  1  PLL reset, active-high
enclk  out  NUM_CLK  per-output PLL clock enables
sys_rstn  out  1  system reset, active-low, registered
ready  out  1  sequence complete, clocks running
fail  out  1  lock never achieved within MAX_RETRY retries
retry_cnt  out  4  timeout retries in current sequence, saturating

Behaviour:
- One clock (clkin). Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: pll_reset=1, enclk=0, sys_rstn=0, ready=0, fail=0, retry_cnt=0, state=S_PRST, all counters 0.
- pll_lock passes through a 2-flop synchronizer to produce lock_s. Latency is 2 clkin cycles. All decisions use lock_s only.
- S_PRST:
  - pll_reset=1.
  - After RST_CYCLES cycles in this state, go to S_WLOCK. pll_reset is 0 from the first S_WLOCK cycle.
- S_WLOCK:
  - Timer counts from 0.
  - lock_s=1: go to S_STAB.
  - Timer reaches LOCK_TIMEOUT-1 with lock_s=0:
    - If retry_cnt==MAX_RETRY, go to S_FAIL.
    - Otherwise increment retry_cnt and go to S_PRST.
- S_STAB:
  - Counter counts consecutive lock_s=1 cycles.
  - STABLE_CYCLES reached: go to S_EN.
  - lock_s=0: go to S_WLOCK with the timer cleared. This does not count as a retry.
- S_EN:
  - enclk[0] is set on the first S_EN cycle.
  - enclk[k] is set k*ENCLK_GAP cycles after entry. Bits stay set once set.
  - RSTN_DELAY cycles after enclk[NUM_CLK-1] is set: sys_rstn=1, ready=1, retry_cnt cleared, go to S_RDY.
- S_RDY: hold all outputs.
- Lock loss in S_EN or S_RDY (lock_s=0):
  - On the next edge: enclk=0, sys_rstn=0, ready=0, pll_reset=1, state=S_PRST.
  - retry_cnt is unchanged.
- S_FAIL:
  - pll_reset=1, enclk=0, sys_rstn=0, ready=0, fail=1.
  - Exit only via restart or rst_n.
- restart=1 in any state (including S_FAIL):
  - Same effect as lock loss, and additionally clears retry_cnt and fail.
  - Priority: restart > lock loss > timeout.
- Counters are sized as $clog2 of the largest parameter plus 1. No counter wraps; each is cleared on every state entry.
- rst_n asserted mid-sequence returns all outputs to their reset values immediately (asynchronous).

Test Plan:
Use parameters RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, ENCLK_GAP=2, RSTN_DELAY=3, MAX_RETRY=2, NUM_CLK=5.
1. Nominal: release rst_n; pll_lock=1 at cycle 6 -> pll_reset low after cycle 4. Five enclk bits rise 2 cycles apart starting after 8 stable cycles. sys_rstn and ready rise 3 cycles after enclk=5'b11111. retry_cnt=0.
2. Timeout retry: hold pll_lock=0 for 2 attempts, then raise it -> pll_reset re-pulses twice, retry_cnt steps 1,2; sequence completes, retry_cnt cleared to 0 at ready.
3. Hard fail: pll_lock=0 forever -> after 3 timeouts fail=1, pll_reset=1, enclk=0, sys_rstn=0. A restart pulse clears fail and retry_cnt and re-enters S_PRST.
4. Lock glitch in S_STAB: drop pll_lock for 1 cycle at stable count 5 -> no enclk bit set, stable count restarts, retry_cnt unchanged, pll_reset stays 0.
5. Lock loss mid-S_EN: drop pll_lock after enclk=5'b00111 -> 2 sync cycles + 1 later enclk=0, pll_reset=1, sys_rstn=0; full re-sequence follows.
6. Simultaneous restart and lock loss in S_RDY, then rst_n asserted mid-S_EN -> restart path taken (retry_cnt=0). On rst_n, all outputs return to reset values with no clock edge.
